noc_rx_endpoint: RTL and testbench

NOC_RX_ENDPOINT -- requirements
Module: noc_rx_endpoint

---
 rtl/noc_rx_endpoint_pkg.sv | 18 +
 rtl/noc_rx_endpoint_fifo.sv | 75 +++++++
 rtl/noc_rx_endpoint.sv | 113 +++++++++++
 tb/tb_noc_rx_endpoint.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/noc_rx_endpoint_pkg.sv
// Shared types and constants for the NoC receive endpoint.
package chronos;

  // Endpoint operating state: normal traffic or discarding buffered flits.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } noc_rx_state_t;

  // Default receive buffer depth (entries).
  localparam int NOC_RX_FIFO_DEPTH = 4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/noc_rx_endpoint_fifo.sv
// Receive buffer for the NoC endpoint: circular FIFO with push, pop and drop.
// Drop removes the head exactly like pop but is used for discarding.
module noc_rx_fifo
  import chronos::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = NOC_RX_FIFO_DEPTH,
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  input  logic                  drop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok;
  logic                  rd_adv;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Never write into a full buffer or read past an empty one.
  assign push_ok = push_i && !full_o;
  assign rd_adv  = (pop_i || drop_i) && !empty_o;

  // Next pointers (power-of-two depth wraps naturally) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_adv)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, rd_adv})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/noc_rx_endpoint.sv
// NoC receive endpoint: buffers incoming flits for the tile, supports a
// flush that discards the buffer one entry per cycle, and optional
// statistics counters enabled by the macro NOC_RX_STATS_EN.
module noc_rx_endpoint
  import chronos::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = NOC_RX_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m_wvalid,
  output logic                  m_wready,
  input  logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [31:0]           rx_count,
  output logic [31:0]           stall_cycles
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  noc_rx_state_t    state_q, state_d;
  logic             flush_done_q, flush_done_d;
  logic             drop;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  noc_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .wdata_i (m_wdata),
    .pop_i   (pop),
    .drop_i  (drop),
    .rdata_o (out_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Handshakes are gated by rstn so both sides see idle while in reset.
  assign m_wready   = rstn && (state_q == RUN) && !fifo_full;
  assign out_valid  = rstn && (state_q == RUN) && !fifo_empty;
  assign push       = m_wvalid && m_wready;
  assign pop        = out_valid && out_ready;
  assign flush_done = flush_done_q;

  // FSM state and completion pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Next state: FLUSH drains one entry per cycle and leaves on the edge
  // where the buffer becomes (or already is) empty.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    drop         = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        drop = !fifo_empty;
        if (fifo_count <= CNT_ONE) begin
          state_d      = RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

`ifdef NOC_RX_STATS_EN
  logic [31:0] rx_count_q;
  logic [31:0] stall_q;

  // Saturating traffic counters: accepted flits and back-pressured cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_count_q <= '0;
      stall_q    <= '0;
    end else begin
      if (push)                  rx_count_q <= sat_inc32(rx_count_q);
      if (m_wvalid && !m_wready) stall_q    <= sat_inc32(stall_q);
    end
  end

  assign rx_count     = rx_count_q;
  assign stall_cycles = stall_q;
`else
  assign rx_count     = 32'd0;
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_noc_rx_endpoint.sv
// Self-checking bench for noc_rx_endpoint: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_noc_rx_endpoint;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          m_wvalid = 1'b0;
  logic          m_wready;
  logic [DW-1:0] m_wdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          flush = 1'b0;
  logic          flush_done;
  logic [31:0]   rx_count;
  logic [31:0]   stall_cycles;

  noc_rx_endpoint #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m_wvalid     (m_wvalid),
    .m_wready     (m_wready),
    .m_wdata      (m_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .flush        (flush),
    .flush_done   (flush_done),
    .rx_count     (rx_count),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffered flits, flushing flag, pending done pulse.
  logic [DW-1:0] mq[$];
  bit            m_flushing = 0;
  bit            m_done = 0;
  longint        m_rx = 0;
  longint        m_stall = 0;

`ifdef NOC_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  function automatic logic [31:0] exp_stat(input longint v);
    return STATS ? sat32(v) : 32'd0;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model across the rising edge.
  task automatic step(input logic wv, input logic [DW-1:0] wd,
                      input logic ordy, input logic fl);
    bit e_wr, e_ov, acc, pp, go_run;
    @(negedge clk);
    m_wvalid  = wv;
    m_wdata   = wd;
    out_ready = ordy;
    flush     = fl;
    #1;
    e_wr = !m_flushing && (mq.size() < DEPTH);
    e_ov = !m_flushing && (mq.size() != 0);
    chk("m_wready",   {31'd0, m_wready},   {31'd0, e_wr});
    chk("out_valid",  {31'd0, out_valid},  {31'd0, e_ov});
    chk("flush_done", {31'd0, flush_done}, {31'd0, m_done});
    chk("rx_count",     rx_count,     exp_stat(m_rx));
    chk("stall_cycles", stall_cycles, exp_stat(m_stall));
    if (e_ov) chk("out_data", out_data, mq[0]);
    @(posedge clk);
    acc = wv && e_wr;
    pp  = e_ov && ordy;
    if (acc) m_rx++;
    if (wv && !e_wr) m_stall++;
    if (!m_flushing) begin
      m_done = 0;
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(wd);
      if (fl) m_flushing = 1;
    end else begin
      go_run = (mq.size() <= 1);
      if (mq.size() > 0) void'(mq.pop_front());
      m_done = go_run;
      if (go_run) m_flushing = 0;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must go idle at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_m_wready",   {31'd0, m_wready},   32'd0);
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_rx_count",     rx_count,     32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    mq.delete();
    m_flushing = 0;
    m_done = 0;
    m_rx = 0;
    m_stall = 0;
    m_wvalid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single flit with tile ready.
    step(1'b1, 32'hABCDABCD, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("single_rx", rx_count, STATS ? 32'd1 : 32'd0);

    // Fill past depth with tile stalled, then drain in order.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    repeat (3) step(1'b1, 32'd5, 1'b0, 1'b0);
    step(1'b1, 32'd5, 1'b1, 1'b0);
    step(1'b1, 32'd5, 1'b1, 1'b0);
    repeat (6) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("fill_rx",    rx_count,     STATS ? 32'd5 : 32'd0);
    chk("fill_stall", stall_cycles, STATS ? 32'd5 : 32'd0);

    // Back-to-back streaming of 100 flits.
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 32'h1000 + DW'(i), 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("stream_rx", rx_count, STATS ? 32'd100 : 32'd0);

    // Flush with three entries, then a new flit goes through.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'hF0 + DW'(i), 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 32'h12345678, 1'b0, 1'b0);
    step(1'b1, 32'h12345678, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush on an empty buffer.
    step(1'b0, 32'd0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0);

    // Reset in the middle of a flush with two entries buffered.
    do_reset();
    step(1'b1, 32'hAA, 1'b0, 1'b0);
    step(1'b1, 32'hBB, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'hCC, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 9) < 7, $urandom(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
